// File: rtl/memory_stream_reader_pkg.sv
// Shared constants for the memory stream reader: FSM state encodings and
// the depth of the output staging FIFO.
package memory_stream_reader_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [1:0] FIFO_DEPTH = 2'd2;

   // Width of one FIFO entry: {data, address, last}.
   function automatic int payload_width(input int address_width, input int data_width);
      return data_width + address_width + 1;
   endfunction

endpackage

// File: rtl/memory_stream_reader_fifo2.sv
// Two-entry synchronous FIFO used to stage read words in front of the
// stream interface; push and pop may coincide at any occupancy.
module stream_fifo2
   import memory_stream_reader_pkg::*;
#(
   parameter int WIDTH = 43
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_mem [int'(FIFO_DEPTH)];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_pop  = i_pop && (r_count != 2'd0);
   assign w_do_push = i_push && ((r_count != FIFO_DEPTH) || w_do_pop);

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         // NOTE: the storage is reset as well so the stream outputs read zero after reset.
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         // NOTE: non-blocking updates, so every register here sees pre-edge values.
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 2'd1;
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - 2'd1;
         end
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == 2'd0);
   assign o_full  = (r_count == FIFO_DEPTH);
   assign o_count = r_count;

endmodule

// File: rtl/memory_stream_reader.sv
// Walks a contiguous word range of a synchronous-read memory and streams
// each word, with its address and a last flag, over valid/ready.
module memory_stream_reader
   import memory_stream_reader_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 10,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_address,
   input  logic [ADDRESS_WIDTH:0]   word_count,
   output logic                     busy,
   output logic                     done,
   output logic                     memory_read_enable,
   output logic [ADDRESS_WIDTH-1:0] memory_address,
   input  logic [DATA_WIDTH-1:0]    memory_read_data,
   output logic                     stream_valid,
   input  logic                     stream_ready,
   output logic [DATA_WIDTH-1:0]    stream_data,
   output logic [ADDRESS_WIDTH-1:0] stream_address,
   output logic                     stream_last
);

   localparam int PAYLOAD_WIDTH = payload_width(ADDRESS_WIDTH, DATA_WIDTH);
   localparam logic [ADDRESS_WIDTH:0] COUNT_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

   logic [1:0]               r_state;
   logic [ADDRESS_WIDTH-1:0] r_base;
   logic [ADDRESS_WIDTH:0]   r_word_count;
   logic [ADDRESS_WIDTH:0]   r_issue_count;
   logic [ADDRESS_WIDTH:0]   r_receive_count;
   logic                     r_inflight;
   logic [ADDRESS_WIDTH-1:0] r_inflight_address;
   logic                     r_inflight_last;

   logic                     w_pop;
   logic                     w_issue;
   logic                     w_issue_last;
   logic [2:0]               w_load;
   logic [ADDRESS_WIDTH:0]   w_receive_next;
   logic [1:0]               w_fifo_count;
   logic                     w_empty;
   logic                     w_full;
   logic [PAYLOAD_WIDTH-1:0] w_push_payload;
   logic [PAYLOAD_WIDTH-1:0] w_head;

   assign w_pop          = stream_valid && stream_ready;
   assign w_receive_next = w_pop ? (r_receive_count + COUNT_ONE) : r_receive_count;
   assign w_issue_last   = (r_issue_count == (r_word_count - COUNT_ONE));

   // A word leaving the FIFO this cycle frees its slot, which keeps a
   // continuously-ready consumer fed at one word per cycle.
   always_comb begin
      // NOTE: defaults first, so no path leaves a signal unassigned and no latch is inferred.
      w_load  = {1'b0, w_fifo_count} + {2'b00, r_inflight};
      w_issue = 1'b0;
      if (w_pop) begin
         w_load = w_load - 3'd1;
      end
      if ((r_state == ST_READ) && enable && (r_issue_count != r_word_count) && (w_load < 3'd2)) begin
         w_issue = 1'b1;
      end
   end

   assign memory_read_enable = w_issue;
   assign memory_address     = r_base + r_issue_count[ADDRESS_WIDTH-1:0];

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state            <= ST_IDLE;
         r_base             <= '0;
         r_word_count       <= '0;
         r_issue_count      <= '0;
         r_receive_count    <= '0;
         r_inflight         <= 1'b0;
         r_inflight_address <= '0;
         r_inflight_last    <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_address <= memory_address;
            r_inflight_last    <= w_issue_last;
            r_issue_count      <= r_issue_count + COUNT_ONE;
         end
         if (w_pop) begin
            r_receive_count <= w_receive_next;
         end
         if (enable) begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_base          <= base_address;
                     r_word_count    <= word_count;
                     r_issue_count   <= '0;
                     r_receive_count <= '0;
                     r_state         <= (word_count == '0) ? ST_DONE : ST_READ;
                  end
               end
               ST_READ: begin
                  if (w_issue && w_issue_last) begin
                     r_state <= ST_DRAIN;
                  end
               end
               ST_DRAIN: begin
                  if ((w_receive_next == r_word_count) && !r_inflight) begin
                     r_state <= ST_DONE;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Read data is captured unconditionally one cycle after issue.
   assign w_push_payload = {memory_read_data, r_inflight_address, r_inflight_last};

   stream_fifo2 #(
      .WIDTH (PAYLOAD_WIDTH)
   ) u_fifo (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_push    (r_inflight),
      .i_data    (w_push_payload),
      .i_pop     (w_pop),
      .o_data    (w_head),
      .o_empty   (w_empty),
      .o_full    (w_full),
      .o_count   (w_fifo_count)
   );

   assign {stream_data, stream_address, stream_last} = w_head;
   assign stream_valid = !w_empty;
   assign busy         = (r_state == ST_READ) || (r_state == ST_DRAIN);
   assign done         = (r_state == ST_DONE);

   // The issue rule must always leave room for the word returning this cycle.
   a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
      r_inflight |-> (!w_full || w_pop));

endmodule

// File: tb/tb_memory_stream_reader.sv
// Directed bench: a queue-based model predicts the stream, busy and done;
// literal expectations per scenario pin the model itself.
module tb_memory_stream_reader;

   localparam int AW = 10;
   localparam int DW = 32;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [AW-1:0] addr;
      logic          last;
   } word_t;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          enable;
   logic          start;
   logic [AW-1:0] base_address;
   logic [AW:0]   word_count;
   logic          busy;
   logic          done;
   logic          memory_read_enable;
   logic [AW-1:0] memory_address;
   logic [DW-1:0] memory_read_data;
   logic          stream_valid;
   logic          stream_ready;
   logic [DW-1:0] stream_data;
   logic [AW-1:0] stream_address;
   logic          stream_last;

   always #5 clock = ~clock;

   memory_stream_reader #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW)
   ) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .enable             (enable),
      .start              (start),
      .base_address       (base_address),
      .word_count         (word_count),
      .busy               (busy),
      .done               (done),
      .memory_read_enable (memory_read_enable),
      .memory_address     (memory_address),
      .memory_read_data   (memory_read_data),
      .stream_valid       (stream_valid),
      .stream_ready       (stream_ready),
      .stream_data        (stream_data),
      .stream_address     (stream_address),
      .stream_last        (stream_last)
   );

   // Synchronous-read memory: data valid the cycle after the read strobe.
   logic [DW-1:0] mem [1 << AW];
   always @(posedge clock) begin
      if (memory_read_enable) memory_read_data <= mem[memory_address];
   end

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Model state and per-scan observations.
   word_t         exp_q[$];
   bit            mon_en = 1'b0;
   bit            exp_busy = 1'b0;
   bit            exp_done = 1'b0;
   int            issued = 0;
   int            popped = 0;
   int            scan_count = 0;
   logic [AW-1:0] scan_base = '0;
   int            mre_cnt, hs_cnt, done_cnt;
   int            first_valid_cyc, last_hs_cyc, done_cyc, accept_cyc;
   logic [DW-1:0] got_data[$];
   logic [AW-1:0] got_addr[$];
   logic          got_last[$];

   always @(negedge clock) begin : monitor
      word_t         w;
      logic [AW-1:0] ea;
      bit            hs;
      if (mon_en) begin
         hs = stream_valid && stream_ready;
         check("busy", busy, exp_busy);
         check("done", done, exp_done);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (memory_read_enable) begin
            check("issue_allowed", (issued < scan_count) && exp_busy && enable, 1);
            ea = scan_base + AW'(issued);
            check("issue_address", memory_address, ea);
            mre_cnt++;
         end
         if (stream_valid) begin
            check("valid_has_word", issued > popped, 1);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (hs) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 0, 1);
            end else begin
               w = exp_q.pop_front();
               check("stream_data", stream_data, w.data);
               check("stream_address", stream_address, w.addr);
               check("stream_last", stream_last, w.last);
            end
            got_data.push_back(stream_data);
            got_addr.push_back(stream_address);
            got_last.push_back(stream_last);
            hs_cnt++;
            last_hs_cyc = cyc;
         end
         issued += int'(memory_read_enable);
         popped += int'(hs);
         check("occupancy_le_2", (issued - popped) <= 2, 1);

         if (!reset_n) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_q.delete();
            issued = 0;
            popped = 0;
            scan_count = 0;
         end else if (exp_done) begin
            if (enable) exp_done = 1'b0;
         end else if (!exp_busy) begin
            if (start && enable) begin
               accept_cyc = cyc;
               scan_base  = base_address;
               scan_count = int'(word_count);
               issued = 0;
               popped = 0;
               for (int i = 0; i < scan_count; i++) begin
                  w.addr = base_address + AW'(i);
                  w.data = mem[w.addr];
                  w.last = (i == scan_count - 1);
                  exp_q.push_back(w);
               end
               if (scan_count == 0) exp_done = 1'b1;
               else exp_busy = 1'b1;
            end
         end else if (enable && (popped == scan_count)) begin
            exp_busy = 1'b0;
            exp_done = 1'b1;
         end
      end
   end

   int ready_mode  = 0;
   int ready_phase = 0;

   task automatic step();
      @(posedge clock);
      #1;
      ready_phase++;
      if (ready_mode == 0) stream_ready = 1'b1;
      else stream_ready = ((ready_phase % 3) == 0);
   endtask

   task automatic clear_stats();
      mre_cnt = 0; hs_cnt = 0; done_cnt = 0;
      first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; accept_cyc = -1;
      got_data.delete(); got_addr.delete(); got_last.delete();
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((done_cnt == 0) && (n < budget)) begin
         step();
         n++;
      end
      repeat (2) step();
      check("scan_done_pulse_count", done_cnt, 1);
   endtask

   task automatic run_scan(input logic [AW-1:0] base, input logic [AW:0] count, input int budget);
      clear_stats();
      base_address = base;
      word_count   = count;
      start        = 1'b1;
      step();
      start        = 1'b0;
      wait_done(budget);
   endtask

   function automatic logic [63:0] qd(input int i);
      return (i < got_data.size()) ? 64'(got_data[i]) : '1;
   endfunction

   function automatic logic [63:0] qa(input int i);
      return (i < got_addr.size()) ? 64'(got_addr[i]) : '1;
   endfunction

   task automatic check_a_words(input string tag);
      logic [3:0] lv;
      check({tag, "_word_total"}, got_data.size(), 4);
      lv = '0;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_data"}, qd(i), 64'(32'h000000A0 + 32'(i)));
         check({tag, "_addr"}, qa(i), 64'(10'h010 + 10'(i)));
         if (i < got_last.size()) lv[i] = got_last[i];
      end
      check({tag, "_last_flags"}, lv, 4'b1000);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stimulus
      int m0;
      int h0;
      int ones;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE0000 | 32'(i);
      for (int i = 0; i < 4; i++) mem[16 + i] = 32'h000000A0 + 32'(i);

      reset_n = 1'b0; enable = 1'b1; start = 1'b0;
      base_address = '0; word_count = '0; stream_ready = 1'b1;
      clear_stats();
      repeat (2) step();
      check("reset_outputs", {busy, done, memory_read_enable, memory_address, stream_valid,
                              stream_data, stream_address, stream_last}, 0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      step();

      // Basic scan at full rate.
      run_scan(10'h010, 11'd4, 40);
      check_a_words("t1");
      check("t1_first_valid_latency", first_valid_cyc - accept_cyc, 3);
      check("t1_back_to_back", last_hs_cyc - first_valid_cyc, 3);
      check("t1_done_after_last", done_cyc - last_hs_cyc, 1);
      check("t1_reads", mre_cnt, 4);

      // Same scan under backpressure.
      ready_mode = 1;
      run_scan(10'h010, 11'd4, 80);
      ready_mode = 0;
      check_a_words("t2");
      check("t2_reads", mre_cnt, 4);

      // Address wrap past the top of memory.
      run_scan(10'h3FE, 11'd4, 40);
      check("t3_word_total", got_data.size(), 4);
      check("t3_addr0", qa(0), 10'h3FE);
      check("t3_addr1", qa(1), 10'h3FF);
      check("t3_addr2", qa(2), 10'h000);
      check("t3_addr3", qa(3), 10'h001);
      check("t3_data0", qd(0), 32'hC0DE03FE);
      check("t3_data2", qd(2), 32'hC0DE0000);

      // Zero-length scan.
      run_scan(10'h010, 11'd0, 10);
      check("t4_reads", mre_cnt, 0);
      check("t4_words", hs_cnt, 0);
      check("t4_no_valid", first_valid_cyc, -1);
      check("t4_done_latency", done_cyc - accept_cyc, 1);

      // Enable drop with a read in flight, then a start while busy.
      clear_stats();
      base_address = 10'h010; word_count = 11'd4; start = 1'b1;
      step();
      start = 1'b0;
      step();
      enable = 1'b0;
      m0 = mre_cnt;
      h0 = hs_cnt;
      repeat (5) step();
      check("t5_no_issue_while_disabled", mre_cnt - m0, 0);
      check("t5_inflight_word_streamed", hs_cnt - h0, 1);
      check("t5_busy_held", busy, 1);
      enable = 1'b1;
      base_address = 10'h020; word_count = 11'd2; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(40);
      check_a_words("t5");

      // Synchronous reset mid-scan, then a fresh scan.
      clear_stats();
      base_address = 10'h010; word_count = 11'd4; start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      reset_n = 1'b0;
      step();
      check("t6_reset_outputs", {busy, done, memory_read_enable, memory_address, stream_valid,
                                 stream_data, stream_address, stream_last}, 0);
      reset_n = 1'b1;
      repeat (4) step();
      check("t6_no_done_on_abort", done_cnt, 0);
      run_scan(10'h020, 11'd3, 40);
      check("t6_word_total", got_data.size(), 3);
      check("t6_data0", qd(0), 32'hC0DE0020);
      check("t6_data2", qd(2), 32'hC0DE0022);
      check("t6_addr2", qa(2), 10'h022);

      // Full address range starting mid-memory.
      run_scan(10'h155, 11'h400, 1200);
      check("t7_word_total", hs_cnt, 1024);
      check("t7_reads", mre_cnt, 1024);
      check("t7_first_addr", qa(0), 10'h155);
      check("t7_last_addr", qa(1023), 10'h154);
      ones = 0;
      foreach (got_last[i]) ones += int'(got_last[i]);
      check("t7_single_last", ones, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
